eth_header_ctrl: RTL
====================

# eth_header_ctrl

Sequencing controller for the Ethernet header capture path. It accepts AXI-Stream beats from the ingress port and drives `frame_start`/`beat_accept` into the header shift register. It counts header beats and inspects the captured EtherType to decide whether an 802.1Q tag extends the header. It then presents a header-ready handshake to the parser, back-pressures the stream until the parser consumes the header, and detects runt frames.

## Interface
- `DATA_WIDTH`, 64: stream width in bits; multiple of 8, 32..256.
- `BASE_BEATS`, derived as ceil(14 / (DATA_WIDTH/8)): beats needed for an untagged header.
- `VLAN_BEATS`, derived as ceil(18 / (DATA_WIDTH/8)): beats needed for a tagged header.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_axis_tvalid` in 1: ingress beat valid.
- `s_axis_tlast` in 1: ingress last beat of frame.
- `s_axis_tready` out 1: ingress ready.
- `frame_start` out 1: to shift register; pulses with the first accepted beat of a frame.
- `beat_accept` out 1: to shift register; high for every accepted header-phase beat.
- `ethertype_in` in 16: `{header_bytes[12], header_bytes[13]}` from the shift register; valid the cycle after the beat carrying byte 13 is accepted.
- `hdr_valid` out 1: header complete and stable.
- `hdr_ready` in 1: parser consumes the header.
- `hdr_vlan` out 1: header carries an 802.1Q tag; valid with `hdr_valid`.
- `payload_valid` out 1: qualifier, `s_axis_tvalid & s_axis_tready` during the PAYLOAD state.
- `runt_err` out 1: one-cycle pulse when a frame ends before its header completes.
- `frame_cnt` out 16: count of completed headers; wraps.
- `runt_cnt` out 16: count of runt frames; wraps.

## Operation
- Accept = `s_axis_tvalid & s_axis_tready`.
- `beat_cnt` is 4 bits and counts header beats; it clears on entry to IDLE.
- States and transitions:
  - **IDLE**, tready=1. On accept, pulse `frame_start` and `beat_accept` and set `beat_cnt`=1.
    - If tlast and 1<BASE_BEATS: runt, stay IDLE.
    - Else if BASE_BEATS==1: go to CHECK.
    - Else: go to HDR.
  - **HDR**, tready=1. Each accept asserts `beat_accept` and increments `beat_cnt`.
    - If tlast before `beat_cnt` reaches BASE_BEATS: runt, go to IDLE.
    - When `beat_cnt` reaches BASE_BEATS: go to CHECK and record `last_seen`=tlast.
  - **CHECK**, tready=0, one cycle. `tag` = (`ethertype_in`==16'h8100).
    - If `tag` & VLAN_BEATS>BASE_BEATS & !`last_seen`: go to VLAN.
    - If `tag` & VLAN_BEATS>BASE_BEATS & `last_seen`: runt, go to IDLE.
    - Otherwise: go to HOLD, set `hdr_vlan`=`tag`, increment `frame_cnt`.
  - **VLAN**, tready=1. Accept asserts `beat_accept`; go to HOLD with `hdr_vlan`=1 and `last_seen`=tlast, and increment `frame_cnt`.
  - **HOLD**, tready=0, `hdr_valid`=1. On `hdr_ready`, go to IDLE if `last_seen`, else to PAYLOAD.
  - **PAYLOAD**, tready=1. Accepts assert `payload_valid`, never `beat_accept`. tlast with accept returns to IDLE.
- Runt handling: `runt_err` pulses one cycle later (registered) and `runt_cnt` increments. No `hdr_valid` is produced.
- `hdr_vlan` holds its value until the next CHECK or VLAN exit, and clears on reset.
- Counters wrap 16'hFFFF→0.

## Timing
- Reset values: state=IDLE; `s_axis_tready`, `frame_start`, `beat_accept`, `hdr_valid`, `hdr_vlan`, `payload_valid`, `runt_err` all 0; `frame_cnt`=`runt_cnt`=0. `s_axis_tready` is forced 0 while `rst`=1.
- Reset mid-frame: abandon the frame in the next cycle; no `runt_err` and no counter increment. Downstream discards the partial frame.
- `frame_start`, `beat_accept`, `payload_valid` are combinational from state and accept. `hdr_valid` and `runt_err` are registered.
- Untagged latency at DATA_WIDTH=64: beat0 accepted at T, beat1 at T+1, CHECK at T+2, `hdr_valid` at T+3.
- Tagged latency at DATA_WIDTH=64: beat2 accepted at T+3 at the earliest, `hdr_valid` at T+4.
- `hdr_valid` stays high until the cycle `hdr_ready`=1 and deasserts the next cycle. `hdr_ready` asserted outside HOLD is ignored.
- Back-to-back frames: a new frame's first beat is accepted in the cycle after PAYLOAD tlast, or after the HOLD handshake when `last_seen`.
- tvalid gaps in any state hold state and counters.

## Configuration
- `ETH_VLAN_EN` defined: CHECK evaluates `ethertype_in`, the VLAN state exists, and `hdr_vlan` is driven as above.
- `ETH_VLAN_EN` undefined: `tag` is forced 0, the VLAN state is removed, and `hdr_vlan` is tied 0. A tagged frame is treated as untagged, with header complete after BASE_BEATS.

## Test plan
- Untagged 64-bit frame: 4 beats with ethertype 0x0800, `hdr_ready` tied 1 → `frame_start` with beat0, `beat_accept` on beats 0–1, `hdr_valid` at T+3, `hdr_vlan`=0, `payload_valid` on beats 2–3, `frame_cnt`=1.
- Tagged frame with ETH_VLAN_EN, ethertype 0x8100 → `beat_accept` on 3 beats, `hdr_valid` at T+4, `hdr_vlan`=1. Same stimulus without ETH_VLAN_EN → `hdr_valid` at T+3, `hdr_vlan`=0.
- Runt: a single beat with tlast → `runt_err` pulses at T+1, `runt_cnt`=1, no `hdr_valid`, and the next frame is accepted normally.
- Backpressure: `hdr_ready` held 0 for 5 cycles → tready=0 and `hdr_valid`=1 throughout; payload is accepted only after the handshake.
- Header-only 2-beat frame with tlast on beat1 → `hdr_valid` is asserted, then IDLE directly after the handshake, with no `payload_valid`.
- Reset asserted during PAYLOAD → all outputs and counters are 0 the next cycle, and a new frame is accepted after `rst` deasserts.

Source files
------------

// File: rtl/eth_header_ctrl.sv
// Ethernet header capture sequencer: counts header beats, detects 802.1Q tags and runts,
// and holds the stream off until the parser takes the header. Optional tag support: ETH_VLAN_EN.
module eth_header_ctrl #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic        frame_start,
  output logic        beat_accept,
  input  logic [15:0] ethertype_in,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        hdr_vlan,
  output logic        payload_valid,
  output logic        runt_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] runt_cnt
);

  localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int unsigned BASE_BEATS     = (14 + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
  localparam logic [3:0]  BASE_CNT       = 4'(BASE_BEATS);
`ifdef ETH_VLAN_EN
  localparam int unsigned VLAN_BEATS     = (18 + BYTES_PER_BEAT - 1) / BYTES_PER_BEAT;
  localparam bit          VLAN_EXTENDS   = (VLAN_BEATS > BASE_BEATS);
  localparam logic [15:0] TPID_8021Q     = 16'h8100;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_CHECK,
`ifdef ETH_VLAN_EN
    ST_VLAN,
`endif
    ST_HOLD,
    ST_PAYLOAD
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic        last_seen_q, last_seen_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic        runt_err_q, runt_d;
  logic [15:0] frame_cnt_q, runt_cnt_q;
  logic        frame_inc;
  logic        tready_c;
  logic        accept;
`ifdef ETH_VLAN_EN
  logic        hdr_vlan_q, hdr_vlan_d;
  logic        tag;
`else
  logic        unused_ethertype;
  assign unused_ethertype = ^ethertype_in;
`endif

  // Ready depends on state only, so accept never loops back through the next-state logic.
  always_comb begin
    tready_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_HDR, ST_PAYLOAD: tready_c = 1'b1;
`ifdef ETH_VLAN_EN
      ST_VLAN:                     tready_c = 1'b1;
`endif
      default:                     tready_c = 1'b0;
    endcase
  end

  assign s_axis_tready = tready_c & ~rst;
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Next-state and strobe decode.
  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    last_seen_d   = last_seen_q;
    hdr_valid_d   = hdr_valid_q;
    runt_d        = 1'b0;
    frame_inc     = 1'b0;
    frame_start   = 1'b0;
    beat_accept   = 1'b0;
    payload_valid = 1'b0;
`ifdef ETH_VLAN_EN
    hdr_vlan_d    = hdr_vlan_q;
    tag           = (ethertype_in == TPID_8021Q);
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          frame_start = 1'b1;
          beat_accept = 1'b1;
          beat_cnt_d  = 4'd1;
          if (s_axis_tlast && (BASE_CNT > 4'd1)) begin
            runt_d     = 1'b1;
            beat_cnt_d = 4'd0;
          end else if (BASE_CNT == 4'd1) begin
            state_d     = ST_CHECK;
            last_seen_d = s_axis_tlast;
          end else begin
            state_d = ST_HDR;
          end
        end
      end
      ST_HDR: begin
        if (accept) begin
          beat_accept = 1'b1;
          beat_cnt_d  = beat_cnt_q + 4'd1;
          if ((beat_cnt_q + 4'd1) == BASE_CNT) begin
            state_d     = ST_CHECK;
            last_seen_d = s_axis_tlast;
          end else if (s_axis_tlast) begin
            state_d = ST_IDLE;
            runt_d  = 1'b1;
          end
        end
      end
      ST_CHECK: begin
`ifdef ETH_VLAN_EN
        if (tag && VLAN_EXTENDS) begin
          if (last_seen_q) begin
            state_d = ST_IDLE;
            runt_d  = 1'b1;
          end else begin
            state_d = ST_VLAN;
          end
        end else begin
          state_d     = ST_HOLD;
          hdr_valid_d = 1'b1;
          hdr_vlan_d  = tag;
          frame_inc   = 1'b1;
        end
`else
        state_d     = ST_HOLD;
        hdr_valid_d = 1'b1;
        frame_inc   = 1'b1;
`endif
      end
`ifdef ETH_VLAN_EN
      ST_VLAN: begin
        if (accept) begin
          beat_accept = 1'b1;
          last_seen_d = s_axis_tlast;
          state_d     = ST_HOLD;
          hdr_valid_d = 1'b1;
          hdr_vlan_d  = 1'b1;
          frame_inc   = 1'b1;
        end
      end
`endif
      ST_HOLD: begin
        if (hdr_ready) begin
          hdr_valid_d = 1'b0;
          state_d     = last_seen_q ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          payload_valid = 1'b1;
          if (s_axis_tlast) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Header beat count restarts whenever a frame is left behind.
    if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) beat_cnt_d = 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= 4'd0;
      last_seen_q <= 1'b0;
      hdr_valid_q <= 1'b0;
      runt_err_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      runt_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      last_seen_q <= last_seen_d;
      hdr_valid_q <= hdr_valid_d;
      runt_err_q  <= runt_d;
      frame_cnt_q <= frame_cnt_q + 16'(frame_inc);
      runt_cnt_q  <= runt_cnt_q + 16'(runt_d);
    end
  end

`ifdef ETH_VLAN_EN
  always_ff @(posedge clk) begin
    if (rst) hdr_vlan_q <= 1'b0;
    else     hdr_vlan_q <= hdr_vlan_d;
  end
  assign hdr_vlan = hdr_vlan_q;
`else
  assign hdr_vlan = 1'b0;
`endif

  assign hdr_valid = hdr_valid_q;
  assign runt_err  = runt_err_q;
  assign frame_cnt = frame_cnt_q;
  assign runt_cnt  = runt_cnt_q;

endmodule
